// File: rtl/led_frame_serializer.sv
// LED matrix link transmitter: takes a parallel frame over valid/ready, shifts it
// out MSB-first with a generated shift clock, then pulses strobe to latch it.
module led_frame_serializer #(
  parameter int unsigned NBITS      = 64,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned STROBE_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] frame_data,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_PH = (CLK_DIV > STROBE_LEN) ? CLK_DIV : STROBE_LEN;
  localparam int unsigned PH_W   = $clog2(MAX_PH) + 1;
  localparam int unsigned CNT_W  = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [NBITS-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [PH_W-1:0]    ph_cnt, ph_cnt_nxt;
  logic               sdata_nxt, sclk_nxt, strobe_nxt, busy_nxt, ready_nxt, done_nxt;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ph_cnt      <= '0;
      sdata       <= 1'b0;
      sclk        <= 1'b0;
      strobe      <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b1;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      ph_cnt      <= ph_cnt_nxt;
      sdata       <= sdata_nxt;
      sclk        <= sclk_nxt;
      strobe      <= strobe_nxt;
      busy        <= busy_nxt;
      frame_ready <= ready_nxt;
      done        <= done_nxt;
    end
  end

  // Next state; outputs are decoded from the next state so they land registered
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ph_cnt_nxt  = ph_cnt;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          shreg_nxt   = frame_data;
          bit_cnt_nxt = CNT_W'(NBITS - 1);
          ph_cnt_nxt  = PH_W'(CLK_DIV - 1);
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (ph_cnt == '0) begin
          ph_cnt_nxt = PH_W'(CLK_DIV - 1);
          state_nxt  = HIGH;
        end else begin
          ph_cnt_nxt = ph_cnt - PH_W'(1);
        end
      end
      HIGH: begin
        if (ph_cnt == '0) begin
          if (bit_cnt == '0) begin
            ph_cnt_nxt = PH_W'(STROBE_LEN - 1);
            state_nxt  = LATCH;
          end else begin
            shreg_nxt   = {shreg[NBITS-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt - CNT_W'(1);
            ph_cnt_nxt  = PH_W'(CLK_DIV - 1);
            state_nxt   = SETUP;
          end
        end else begin
          ph_cnt_nxt = ph_cnt - PH_W'(1);
        end
      end
      LATCH: begin
        if (ph_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ph_cnt_nxt = ph_cnt - PH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // sdata only moves when a new bit enters SETUP, so it is steady through HIGH
    sdata_nxt  = ((state_nxt == SETUP) || (state_nxt == HIGH)) ? shreg_nxt[NBITS-1] : 1'b0;
    sclk_nxt   = (state_nxt == HIGH);
    strobe_nxt = (state_nxt == LATCH);
    busy_nxt   = (state_nxt != IDLE);
    ready_nxt  = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: two instances (default timing and CLK_DIV=3,
// STROBE_LEN=1) checked every cycle against a timing model and a chain scoreboard.
module tb_led_frame_serializer;

  localparam int NB    = 64;
  localparam int NINST = 2;
  localparam int TMO   = 2000;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] fdata  [NINST];
  logic          fvalid [NINST];
  logic          frdy   [NINST];
  logic          fdone  [NINST];
  logic [5:0]    obs    [NINST];

  int n_cmp   = 0;
  int n_bad   = 0;
  int ecnt    = 0;
  int tmo_cnt = 0;
  bit end_req  = 1'b0;
  bit end_done = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    logic ready, sdata, sclk, strobe, busy, done;
    led_frame_serializer #(
      .NBITS      (NB),
      .CLK_DIV    ((g == 1) ? 3 : 1),
      .STROBE_LEN ((g == 1) ? 1 : 2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_data  (fdata[g]),
      .frame_valid (fvalid[g]),
      .frame_ready (ready),
      .sdata       (sdata),
      .sclk        (sclk),
      .strobe      (strobe),
      .busy        (busy),
      .done        (done)
    );
    assign obs[g]   = {ready, busy, sdata, sclk, strobe, done};
    assign frdy[g]  = ready;
    assign fdone[g] = done;
  end

  function automatic int cd_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic int sl_of(input int g);
    return (g == 1) ? 1 : 2;
  endfunction

  // Offset (in clk edges after the accepting edge) at which done is seen
  function automatic int done_off(input int g);
    return 2 * cd_of(g) * NB + sl_of(g);
  endfunction

  // Expected {ready,busy,sdata,sclk,strobe,done} at offset o into a frame
  function automatic logic [5:0] expect_out(input int g, input int o, input logic [NB-1:0] f);
    int cd, shift_len, bit_idx;
    logic [5:0] v;
    cd        = cd_of(g);
    shift_len = 2 * cd * NB;
    if (o < shift_len) begin
      bit_idx = o / (2 * cd);
      v = {1'b0, 1'b1, f[NB-1-bit_idx], ((o / cd) % 2) == 1, 1'b0, 1'b0};
    end else if (o < shift_len + sl_of(g)) begin
      v = 6'b010010;
    end else begin
      v = 6'b100001;
    end
    return v;
  endfunction

  // Reference model state
  bit            in_frame [NINST];
  int            acc      [NINST];
  logic [NB-1:0] cur      [NINST];
  logic [NB-1:0] chain    [NINST];
  bit            psclk    [NINST];
  bit            pstb     [NINST];
  int            rises    [NINST];
  logic [NB-1:0] sbq      [NINST][$];

  always @(posedge clk) ecnt++;

  // Monitor: per-cycle output check, driver-chain latch check, acceptance tracking
  always @(negedge clk) begin
    for (int g = 0; g < NINST; g++) begin
      logic [5:0]    exp_v;
      logic [NB-1:0] exp_f;
      int            o;
      bit            done_cyc;
      o        = ecnt - acc[g];
      done_cyc = 1'b0;
      if (!rst_n) begin
        exp_v       = 6'b100000;
        in_frame[g] = 1'b0;
        chain[g]    = '0;
        psclk[g]    = 1'b0;
        pstb[g]     = 1'b0;
        rises[g]    = 0;
        sbq[g].delete();
      end else if (in_frame[g]) begin
        exp_v    = expect_out(g, o, cur[g]);
        done_cyc = (o == done_off(g));
      end else begin
        exp_v = 6'b100000;
      end

      n_cmp++;
      if (obs[g] !== exp_v) begin
        n_bad++;
        $display("FAIL u%0d outputs cyc=%0d off=%0d got=%b exp=%b (ready,busy,sdata,sclk,strobe,done)",
                 g, ecnt, o, obs[g], exp_v);
      end

      if (rst_n) begin
        if (obs[g][2] && !psclk[g]) begin
          chain[g] = {chain[g][NB-2:0], obs[g][3]};
          rises[g]++;
        end
        if (obs[g][1] && !pstb[g]) begin
          n_cmp++;
          if (sbq[g].size() == 0) begin
            n_bad++;
            $display("FAIL u%0d latch cyc=%0d got strobe with no frame outstanding", g, ecnt);
          end else begin
            exp_f = sbq[g].pop_front();
            if (chain[g] !== exp_f || rises[g] != NB) begin
              n_bad++;
              $display("FAIL u%0d latch cyc=%0d got=%h rises=%0d exp=%h rises=%0d",
                       g, ecnt, chain[g], rises[g], exp_f, NB);
            end
          end
          rises[g] = 0;
        end
        psclk[g] = obs[g][2];
        pstb[g]  = obs[g][1];

        if ((!in_frame[g] || done_cyc) && fvalid[g] === 1'b1) begin
          in_frame[g] = 1'b1;
          acc[g]      = ecnt + 1;
          cur[g]      = fdata[g];
          sbq[g].push_back(fdata[g]);
        end else if (done_cyc) begin
          in_frame[g] = 1'b0;
        end
      end
    end

    if (end_req && !end_done) begin
      for (int g = 0; g < NINST; g++) begin
        n_cmp++;
        if (sbq[g].size() != 0) begin
          n_bad++;
          $display("FAIL u%0d drain got=%0d frames unlatched exp=0", g, sbq[g].size());
        end
      end
      n_cmp++;
      if (tmo_cnt != 0) begin
        n_bad++;
        $display("FAIL wait_timeout got=%0d expired waits exp=0", tmo_cnt);
      end
      end_done = 1'b1;
    end
  end

  // Present a frame and hold valid until accepted; optionally follow with a
  // busy-time frame_valid that must be ignored
  task automatic send(input int g, input logic [NB-1:0] d, input bit junk);
    int w;
    w         = 0;
    fdata[g]  = d;
    fvalid[g] = 1'b1;
    @(negedge clk);
    while (frdy[g] !== 1'b1 && w < TMO) begin
      @(negedge clk);
      w++;
    end
    if (w >= TMO) tmo_cnt++;
    @(posedge clk);
    #2;
    fvalid[g] = 1'b0;
    if (junk) begin
      fdata[g]  = ~d ^ {$urandom, $urandom};
      fvalid[g] = 1'b1;
      repeat (40) @(posedge clk);
      #2;
      fvalid[g] = 1'b0;
    end
  endtask

  task automatic wait_done(input int g);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (fdone[g] !== 1'b1 && w < TMO);
    if (w >= TMO) tmo_cnt++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int g = 0; g < NINST; g++) begin
      fdata[g]  = '0;
      fvalid[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;

    // Single-bit markers at both ends of the frame
    send(0, 64'h8000_0000_0000_0001, 1'b0);
    wait_done(0);

    // Slow instance
    send(1, {$urandom, $urandom}, 1'b0);
    wait_done(1);

    // frame_valid with new data while busy must be ignored
    send(0, {$urandom, $urandom}, 1'b1);
    wait_done(0);
    send(0, {$urandom, $urandom}, 1'b1);
    wait_done(0);
    send(1, {$urandom, $urandom}, 1'b1);
    wait_done(1);

    // Random stream with back-to-back accepts in the done cycle and random gaps
    for (int i = 0; i < 50; i++) begin
      send(0, {$urandom, $urandom}, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        wait_done(0);
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #2;
      end
    end
    wait_done(0);
    for (int i = 0; i < 8; i++) begin
      send(1, {$urandom, $urandom}, 1'b0);
    end
    wait_done(1);

    // Abort at bit 30, then a clean frame
    send(0, {$urandom, $urandom}, 1'b0);
    repeat (60) @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    send(0, {$urandom, $urandom}, 1'b0);
    wait_done(0);
    repeat (10) @(posedge clk);
    #2;

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
